ras_commit_mirror: RTL and testbench
====================================

// Module: ras_commit_mirror
// PURPOSE
//  Architectural (commit-side) copy of the return-address stack. Tracks retired calls/returns
//  with the same {count,addr} recursion compression as the speculative RAS and drives the
//  RAS reload interface on a pipeline flush. This restores the front-end RAS to the committed state.
// PARAMETERS
//  STACKDEEP   16  physical entries; entries 0..STACKDEEP-2 are used, top entry unused
//  STACKPTRW   4   stack pointer width
//  STACKWIDE   32  return address width
//  RECURCOUNT  7   recursion count width; entry = {count[RECURCOUNT-1:0], addr[STACKWIDE-1:0]}
// PORTS
//  Clk          in   1                               clock, all state on posedge
//  Rest         in   1                               synchronous reset, active-low
//  CommitCall   in   1                               a call retired this cycle
//  CommitAddr   in   STACKWIDE                       return address (PC+4) of retired call
//  CommitRet    in   1                               a return retired this cycle
//  Flush        in   1                               pipeline flush request
//  RELOAD       out  1                               one-cycle reload strobe to speculative RAS
//  RELOADPTR    out  STACKPTRW                       committed stack pointer
//  RELOADLINES  out  (STACKDEEP-1)*(STACKWIDE+RECURCOUNT)  entry i at slice [i*EW +: EW], EW=STACKWIDE+RECURCOUNT
//  OVERFLOW     out  1                               sticky: call dropped because stack full
//  UNDERFLOW    out  1                               sticky: return retired with stack empty
// BEHAVIOUR
//  - Reset (Rest==0 at posedge): ptr=0, all entries 0, RELOAD=0, RELOADPTR=0, RELOADLINES=0, flags=0.
//  - Top of stack is entry[ptr-1]; empty when ptr==0; full when ptr==STACKDEEP-1 (15).
//  - Return (CommitRet): empty -> no change, UNDERFLOW<=1. Else top count>1 -> count-1, ptr kept;
//    else entry[ptr-1]<=0, ptr-1.
//  - Call (CommitCall), evaluated on the state AFTER any same-cycle return:
//    ptr!=0, top addr==CommitAddr, count<2^RECURCOUNT-1 -> top count+1, ptr kept.
//    Else if not full -> entry[ptr]<={1,CommitAddr}, ptr+1.
//    Else the call is dropped, OVERFLOW<=1.
//    A saturated count compares as a mismatch, so a new entry is pushed.
//  - Call and Return in the same cycle: return applied first, then call; one-cycle combined update.
//  - Flush at cycle t: RELOAD=1 in cycle t+1 only; RELOADPTR/RELOADLINES in t+1 equal mirror state
//    after cycle t's commit updates. Flush held N cycles -> RELOAD high N cycles, each carrying that
//    cycle's state. Flush has no effect on mirror contents.
//  - RELOADPTR/RELOADLINES are registered copies of the mirror and valid every cycle.
//    Consumers sample them only while RELOAD=1.
//  - Latency: commit update visible on RELOADLINES 1 cycle after the commit edge.
//  - OVERFLOW/UNDERFLOW clear only on reset.
//  - Reset mid-flush: RELOAD forced 0 next cycle, no reload issued.
//  - Count width arithmetic: no wrap; increment guarded by saturation check, decrement only when >1.
// CONFIGURATION
//  RAS_MIRROR_STAT_EN defined: adds outputs ReloadCnt[15:0] and DropCnt[15:0], saturating at 16'hFFFF.
//    ReloadCnt increments per RELOAD cycle. DropCnt increments per dropped call or underflowed return.
//    Both reset to 0.
//  Undefined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1. Reset, Flush -> next cycle RELOAD=1, RELOADPTR=0, all lines 0; following cycle RELOAD=0.
//  2. Calls 0x100,0x200,0x200,0x200 then Flush -> RELOADPTR=2, line0={1,0x100}, line1={3,0x200}.
//  3. From test 2: Ret,Ret,Ret,Ret -> line1 count 2,1 then cleared, ptr 2->1->0; fifth Ret sets UNDERFLOW.
//  4. 15 distinct calls -> ptr=15, OVERFLOW=0; 16th call -> ptr=15, lines unchanged, OVERFLOW=1.
//  5. 128 calls to 0x300 -> line0={127,0x300}, line1={1,0x300}, ptr=2.
//  6. Top {1,0x100}, same-cycle Ret+Call 0x400 with Flush -> RELOAD next cycle, ptr=1, line0={1,0x400}.

Source files
------------

// File: rtl/ras_commit_mirror.sv
`default_nettype none
// ras_commit_mirror: committed return-address stack mirror that reloads the speculative RAS on flush.
// Optional build macro RAS_MIRROR_STAT_EN adds reload/drop counters.  Rev 1.0
module ras_commit_mirror #(
   parameter int STACKDEEP  = 16,
   parameter int STACKPTRW  = 4,
   parameter int STACKWIDE  = 32,
   parameter int RECURCOUNT = 7
) (
   input  logic                                                Clk,
   input  logic                                                Rest,
   input  logic                                                CommitCall,
   input  logic [STACKWIDE-1:0]                                CommitAddr,
   input  logic                                                CommitRet,
   input  logic                                                Flush,
   output logic                                                RELOAD,
   output logic [STACKPTRW-1:0]                                RELOADPTR,
   output logic [(STACKDEEP-1)*(STACKWIDE+RECURCOUNT)-1:0]     RELOADLINES,
   output logic                                                OVERFLOW,
   output logic                                                UNDERFLOW
`ifdef RAS_MIRROR_STAT_EN
   ,
   output logic [15:0]                                         ReloadCnt,
   output logic [15:0]                                         DropCnt
`endif
);

   localparam int EW   = STACKWIDE + RECURCOUNT;
   localparam int NENT = STACKDEEP - 1;
   localparam logic [STACKPTRW-1:0]  FULL_PTR = STACKPTRW'(NENT);
   localparam logic [RECURCOUNT-1:0] CNT_MAX  = '1;
   localparam logic [RECURCOUNT-1:0] CNT_ONE  = RECURCOUNT'(1);

   logic [EW-1:0]        ent   [NENT];
   logic [EW-1:0]        ent_n [NENT];
   logic [STACKPTRW-1:0] ptr, ptr_n, top_r, top_c;
   logic                 ovf_set, udf_set;
   logic                 reload, overflow, underflow;

   // Return is resolved first; the call then sees the post-return stack.
   always_comb begin
      ent_n   = ent;
      ptr_n   = ptr;
      ovf_set = 1'b0;
      udf_set = 1'b0;
      top_r   = ptr - 1'b1;
      top_c   = '0;
      if (CommitRet) begin
         if (ptr == '0) begin
            udf_set = 1'b1;
         end else if (ent[top_r][EW-1:STACKWIDE] > CNT_ONE) begin
            ent_n[top_r][EW-1:STACKWIDE] = ent[top_r][EW-1:STACKWIDE] - CNT_ONE;
         end else begin
            ent_n[top_r] = '0;
            ptr_n        = top_r;
         end
      end
      top_c = ptr_n - 1'b1;
      if (CommitCall) begin
         // A saturated count is treated as a mismatch so a fresh entry is pushed.
         if (ptr_n != '0 && ent_n[top_c][STACKWIDE-1:0] == CommitAddr &&
             ent_n[top_c][EW-1:STACKWIDE] != CNT_MAX) begin
            ent_n[top_c][EW-1:STACKWIDE] = ent_n[top_c][EW-1:STACKWIDE] + CNT_ONE;
         end else if (ptr_n != FULL_PTR) begin
            ent_n[ptr_n] = {CNT_ONE, CommitAddr};
            ptr_n        = ptr_n + 1'b1;
         end else begin
            ovf_set = 1'b1;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rest) begin
         ptr       <= '0;
         reload    <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         for (int i = 0; i < NENT; i++) begin
            ent[i] <= '0;
         end
      end else begin
         ptr    <= ptr_n;
         ent    <= ent_n;
         reload <= Flush;
         if (ovf_set) overflow  <= 1'b1;
         if (udf_set) underflow <= 1'b1;
      end
   end

   assign RELOAD    = reload;
   assign RELOADPTR = ptr;
   assign OVERFLOW  = overflow;
   assign UNDERFLOW = underflow;

   for (genvar i = 0; i < NENT; i++) begin : g_pack
      assign RELOADLINES[i*EW +: EW] = ent[i];
   end

`ifdef RAS_MIRROR_STAT_EN
   logic [15:0] reload_cnt, drop_cnt;

   always_ff @(posedge Clk) begin
      if (!Rest) begin
         reload_cnt <= '0;
         drop_cnt   <= '0;
      end else begin
         if (reload && reload_cnt != 16'hFFFF) reload_cnt <= reload_cnt + 16'd1;
         if ((ovf_set || udf_set) && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
   end

   assign ReloadCnt = reload_cnt;
   assign DropCnt   = drop_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ras_commit_mirror.sv
`default_nettype none
// tb_ras_commit_mirror: directed self-checking bench for the commit-side RAS mirror.
module tb_ras_commit_mirror;

   logic          Clk = 1'b0;
   logic          Rest = 1'b0;
   logic          CommitCall = 1'b0;
   logic [31:0]   CommitAddr = '0;
   logic          CommitRet = 1'b0;
   logic          Flush = 1'b0;
   logic          RELOAD;
   logic [3:0]    RELOADPTR;
   logic [584:0]  RELOADLINES;
   logic          OVERFLOW;
   logic          UNDERFLOW;
`ifdef RAS_MIRROR_STAT_EN
   logic [15:0]   ReloadCnt;
   logic [15:0]   DropCnt;
`endif

   int tests = 0;
   int fails = 0;

   ras_commit_mirror dut (
      .Clk         (Clk),
      .Rest        (Rest),
      .CommitCall  (CommitCall),
      .CommitAddr  (CommitAddr),
      .CommitRet   (CommitRet),
      .Flush       (Flush),
      .RELOAD      (RELOAD),
      .RELOADPTR   (RELOADPTR),
      .RELOADLINES (RELOADLINES),
      .OVERFLOW    (OVERFLOW),
      .UNDERFLOW   (UNDERFLOW)
`ifdef RAS_MIRROR_STAT_EN
      ,
      .ReloadCnt   (ReloadCnt),
      .DropCnt     (DropCnt)
`endif
   );

   always #5 Clk = ~Clk;

   function automatic logic [38:0] line(input int i);
      return RELOADLINES[i*39 +: 39];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply the currently driven inputs for one edge, then return inputs to idle.
   task automatic step();
      @(posedge Clk);
      #1;
      CommitCall = 1'b0;
      CommitRet  = 1'b0;
      Flush      = 1'b0;
   endtask

   task automatic do_reset();
      Rest = 1'b0;
      step();
      Rest = 1'b1;
   endtask

   task automatic call(input logic [31:0] a);
      CommitCall = 1'b1;
      CommitAddr = a;
      step();
   endtask

   initial begin
      // 1: reset state, flush of an empty stack
      Rest = 1'b0;
      step();
      step();
      chk("rst_reload", 64'(RELOAD), 64'd0);
      chk("rst_ptr", 64'(RELOADPTR), 64'd0);
      chk("rst_lines", 64'(RELOADLINES == '0), 64'd1);
      chk("rst_ovf", 64'(OVERFLOW), 64'd0);
      chk("rst_udf", 64'(UNDERFLOW), 64'd0);
      Rest = 1'b1;
      Flush = 1'b1;
      step();
      chk("t1_reload", 64'(RELOAD), 64'd1);
      chk("t1_ptr", 64'(RELOADPTR), 64'd0);
      chk("t1_lines", 64'(RELOADLINES == '0), 64'd1);
      step();
      chk("t1_reload_off", 64'(RELOAD), 64'd0);

      // 2: recursion compression
      call(32'h100);
      call(32'h200);
      call(32'h200);
      call(32'h200);
      Flush = 1'b1;
      step();
      chk("t2_reload", 64'(RELOAD), 64'd1);
      chk("t2_ptr", 64'(RELOADPTR), 64'd2);
      chk("t2_line0", 64'(line(0)), {25'd0, 7'd1, 32'h100});
      chk("t2_line1", 64'(line(1)), {25'd0, 7'd3, 32'h200});

      // 3: returns unwind counts, then entries, then underflow
      CommitRet = 1'b1; step();
      chk("t3_r1_line1", 64'(line(1)), {25'd0, 7'd2, 32'h200});
      chk("t3_r1_ptr", 64'(RELOADPTR), 64'd2);
      CommitRet = 1'b1; step();
      chk("t3_r2_line1", 64'(line(1)), {25'd0, 7'd1, 32'h200});
      CommitRet = 1'b1; step();
      chk("t3_r3_line1", 64'(line(1)), 64'd0);
      chk("t3_r3_ptr", 64'(RELOADPTR), 64'd1);
      CommitRet = 1'b1; step();
      chk("t3_r4_ptr", 64'(RELOADPTR), 64'd0);
      chk("t3_r4_line0", 64'(line(0)), 64'd0);
      chk("t3_r4_udf", 64'(UNDERFLOW), 64'd0);
      CommitRet = 1'b1; step();
      chk("t3_r5_udf", 64'(UNDERFLOW), 64'd1);
      chk("t3_r5_ptr", 64'(RELOADPTR), 64'd0);
      step();
      chk("t3_udf_sticky", 64'(UNDERFLOW), 64'd1);
      do_reset();
      chk("t3_udf_clear", 64'(UNDERFLOW), 64'd0);

      // 4: fill to 15 entries, then overflow
      for (int i = 0; i < 15; i++) call(32'h1000 + 32'(i * 4));
      chk("t4_ptr_full", 64'(RELOADPTR), 64'd15);
      chk("t4_ovf0", 64'(OVERFLOW), 64'd0);
      chk("t4_line14", 64'(line(14)), {25'd0, 7'd1, 32'h1038});
      call(32'h2000);
      chk("t4_ptr_drop", 64'(RELOADPTR), 64'd15);
      chk("t4_ovf1", 64'(OVERFLOW), 64'd1);
      chk("t4_line14_kept", 64'(line(14)), {25'd0, 7'd1, 32'h1038});
      chk("t4_line0_kept", 64'(line(0)), {25'd0, 7'd1, 32'h1000});
      call(32'h1038);
      chk("t4_full_recur", 64'(line(14)), {25'd0, 7'd2, 32'h1038});
      chk("t4_full_ptr", 64'(RELOADPTR), 64'd15);
      do_reset();
      chk("t4_ovf_clear", 64'(OVERFLOW), 64'd0);

      // 5: count saturation pushes a new entry
      for (int i = 0; i < 128; i++) call(32'h300);
      chk("t5_line0", 64'(line(0)), {25'd0, 7'd127, 32'h300});
      chk("t5_line1", 64'(line(1)), {25'd0, 7'd1, 32'h300});
      chk("t5_ptr", 64'(RELOADPTR), 64'd2);
      do_reset();

      // 6: same-cycle return + call + flush
      call(32'h100);
      CommitRet = 1'b1; CommitCall = 1'b1; CommitAddr = 32'h400; Flush = 1'b1;
      step();
      chk("t6_reload", 64'(RELOAD), 64'd1);
      chk("t6_ptr", 64'(RELOADPTR), 64'd1);
      chk("t6_line0", 64'(line(0)), {25'd0, 7'd1, 32'h400});
      call(32'h400);
      CommitRet = 1'b1; CommitCall = 1'b1; CommitAddr = 32'h400;
      step();
      chk("t6_recur_line0", 64'(line(0)), {25'd0, 7'd2, 32'h400});
      chk("t6_recur_ptr", 64'(RELOADPTR), 64'd1);

      // held flush keeps RELOAD high; reset during flush suppresses it
      Flush = 1'b1; step();
      Flush = 1'b1; step();
      chk("hold_reload", 64'(RELOAD), 64'd1);
      Flush = 1'b1; Rest = 1'b0;
      step();
      chk("rst_flush_reload", 64'(RELOAD), 64'd0);
      chk("rst_flush_ptr", 64'(RELOADPTR), 64'd0);
      Rest = 1'b1;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
